// File: rtl/audio_recorder.sv
// audio_recorder: I2S left-channel capture into SRAM.
// Deserializes 16-bit MSB-first samples from the ADC stream and writes one
// word per LRCK frame, starting at i_start_pos. Recording stops on host
// request or after i_end_pos has been written.
module audio_recorder (
  input  logic        i_BCLK,
  input  logic        i_rst,
  input  logic        i_record,
  input  logic        i_pause,
  input  logic [19:0] i_start_pos,
  input  logic [19:0] i_end_pos,
  input  logic        i_ADCLRCK,
  input  logic        i_ADCDAT,
  output logic        o_SRAM_WE,
  output logic [19:0] o_SRAM_ADDR,
  output logic [15:0] o_SRAM_DATA,
  output logic [19:0] o_last_pos,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        pre_lrck_q, pre_lrck_d;
  logic [19:0] pos_q, pos_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bitnum_q, bitnum_d;
  logic [19:0] last_pos_q, last_pos_d;
  logic        done_q, done_d;
  logic        left_start;

  // LRCK falling edge marks the start of a left-channel word.
  assign left_start = pre_lrck_q & ~i_ADCLRCK;

  // Next-state and datapath decode for the capture FSM.
  always_comb begin
    state_d    = state_q;
    pre_lrck_d = i_ADCLRCK;
    pos_d      = pos_q;
    shift_d    = shift_q;
    bitnum_d   = bitnum_q;
    last_pos_d = last_pos_q;
    case (state_q)
      S_IDLE: begin
        pos_d    = i_start_pos;
        bitnum_d = 4'd0;
        if (i_record) state_d = S_WAIT;
      end
      S_WAIT: begin
        bitnum_d = 4'd0;
        // Stop takes precedence over a coincident frame start.
        if (!i_record) state_d = S_DONE;
        else if (left_start && !i_pause) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shift_d  = {shift_q[14:0], i_ADCDAT};
        bitnum_d = bitnum_q + 4'd1;
        // A stop mid-word drops the partial sample.
        if (!i_record) state_d = S_DONE;
        else if (bitnum_q == 4'd15) state_d = S_WRITE;
      end
      S_WRITE: begin
        // The write always completes; i_record is not looked at here.
        last_pos_d = pos_q;
        if (pos_q == i_end_pos) begin
          state_d = S_DONE;
        end else begin
          pos_d   = pos_q + 20'd1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_BCLK) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      pre_lrck_q <= 1'b1;
      pos_q      <= 20'd0;
      shift_q    <= 16'd0;
      bitnum_q   <= 4'd0;
      last_pos_q <= 20'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_lrck_q <= pre_lrck_d;
      pos_q      <= pos_d;
      shift_q    <= shift_d;
      bitnum_q   <= bitnum_d;
      last_pos_q <= last_pos_d;
      done_q     <= done_d;
    end
  end

  assign o_SRAM_WE   = ~(state_q == S_WRITE);
  assign o_SRAM_ADDR = pos_q;
  assign o_SRAM_DATA = shift_q;
  assign o_last_pos  = last_pos_q;
  assign o_done      = done_q;

endmodule

// File: doc/audio_recorder.md
# audio_recorder

I2S capture stage that sits upstream of the SRAM playback block: it deserializes 16-bit mono samples from the WM8731 ADC serial stream (left channel only) and writes one word per LRCK frame into SRAM, starting at a programmable address. Capture stops when the host drops record, or when the end address has been written, which is the memory-full condition. The block reports the last written address so the player can be given a matching end position.

## Interface
Parameters:
- none

Ports:
- i_BCLK  in  1  ADC bit clock; sole clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_record  in  1  level; high = record, low = stop
- i_pause  in  1  level; high = suspend starting new frames
- i_start_pos  in  20  first SRAM word address
- i_end_pos  in  20  last SRAM word address allowed
- i_ADCLRCK  in  1  I2S frame clock; low = left channel
- i_ADCDAT  in  1  I2S serial data, MSB first
- o_SRAM_WE  out  1  SRAM write enable, active low
- o_SRAM_ADDR  out  20  SRAM word address
- o_SRAM_DATA  out  16  SRAM write data
- o_last_pos  out  20  address of the most recent completed write
- o_done  out  1  one-cycle pulse when recording ends

## Operation
- States: S_IDLE, S_WAIT, S_CAPTURE, S_WRITE, S_DONE.
- The block registers i_ADCLRCK into pre_lrck every cycle. A left-start is detected when pre_lrck==1 and i_ADCLRCK==0.
- **S_IDLE**:
  - Load position ← i_start_pos and bitnum ← 0.
  - If i_record=1, go to S_WAIT.
- **S_WAIT**:
  - bitnum ← 0.
  - If i_record=0, go to S_DONE.
  - Else if left-start is detected and i_pause=0, go to S_CAPTURE.
- **S_CAPTURE**:
  - Each cycle: shift ← {shift[14:0], i_ADCDAT} and bitnum ← bitnum+1.
  - At bitnum==15, go to S_WRITE.
  - If i_record=0, go to S_DONE and discard the partial sample.
- **S_WRITE**:
  - o_SRAM_WE=0, o_SRAM_ADDR=position, o_SRAM_DATA=shift.
  - Update o_last_pos ← position.
  - If position==i_end_pos: go to S_DONE and hold position.
  - Else: position ← position+1 and go to S_WAIT.
  - i_record is ignored for this one cycle; the write always completes.
- **S_DONE**:
  - o_done=1 for this cycle, then go to S_IDLE.
- Position arithmetic:
  - position is 20-bit, increments modulo 2^20 (0xFFFFF → 0x00000).
  - The end test is equality only, so a start above the end wraps through 0.
- The right channel is never captured. Pause is honoured only at frame boundaries (S_WAIT); a capture in progress always completes.
- o_SRAM_WE is decoded combinationally from state_r==S_WRITE.
- o_SRAM_ADDR is always position; o_SRAM_DATA is always the shift register; o_done is registered.

## Timing
- Reset (i_rst=1 at a clock edge), effective next cycle:
  - state S_IDLE; o_SRAM_WE=1; o_SRAM_ADDR=0; o_SRAM_DATA=0; o_last_pos=0; o_done=0; pre_lrck=1.
- Reset mid-capture or mid-write aborts immediately. No write is issued after reset; o_done does not pulse.
- Left-start detected in cycle D. Bits are sampled at rising edges D+1..D+16 (MSB at D+1). WE is low during D+17 only.
- Minimum frame is 34 BCLK (32 data + detect + write margin); no backpressure exists.
- o_done rises the cycle after the last write (end hit) or the cycle after i_record is seen low. It is high for exactly 1 cycle.
- If i_record is 0 and a left-start occur in the same S_WAIT cycle, stop wins.
- i_start_pos and i_end_pos are sampled continuously; they must be stable from leaving S_IDLE until o_done.

## Test plan
- **Single frame.** Reset, start=0x00010, end=0x000FF, record=1, one left frame with data 0xA5C3 MSB first.
  - Expect WE low exactly 1 cycle, 17 cycles after detect, with ADDR=0x00010, DATA=0xA5C3.
  - Expect o_last_pos=0x00010.
- **Memory full.** start=0x00100, end=0x00102, four frames with data 0x0001..0x0004.
  - Expect writes 0x0001..0x0003 at 0x100..0x102.
  - Expect o_done pulse 1 cycle after the third write, no fourth write, o_last_pos=0x00102, state IDLE.
- **Stop mid-capture.** Drop record after 8 data bits of the second frame.
  - Expect no second write, o_done pulse next cycle, o_last_pos=start.
- **Pause.** Assert pause during a capture.
  - Expect that frame to still be written.
  - Expect the next two frames skipped with no WE.
  - After release, expect the next frame written at position+1, i.e. no address gap.
- **Wrap.** start=0xFFFFF, end=0x00000, two frames.
  - Expect writes at 0xFFFFF then 0x00000, then o_done.
- **Reset mid-write.** Assert i_rst in the S_WRITE cycle.
  - Expect all outputs at reset values next cycle, WE=1, o_done never asserted.
